// File: rtl/cursor_draw_saveunder_if.sv
// Bus between the mouse-side controller / mirror RAM (master) and the cursor
// draw/save-under engine (slave).
`timescale 1ns/1ps
interface cursor_draw_saveunder_if #(
  parameter int COLOUR_W = 3
);
  // draw_req/erase_req are single-cycle strobes. They are acted on only while
  // busy is low and are silently dropped otherwise, so there is no ready or
  // backpressure. done pulses for one cycle when an accepted operation ends.
  // plot is a one-cycle write strobe per pixel, with plot_x/plot_y/plot_colour
  // qualified by it. ram_q returns mirror data one cycle after ram_address.
  logic                draw_req;
  logic                erase_req;
  logic [7:0]          cur_x;
  logic [6:0]          cur_y;
  logic [COLOUR_W-1:0] cursor_colour;
  logic [14:0]         ram_address;
  logic [COLOUR_W-1:0] ram_q;
  logic [7:0]          plot_x;
  logic [6:0]          plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output draw_req, erase_req, cur_x, cur_y, cursor_colour, ram_q,
    input  ram_address, plot_x, plot_y, plot_colour, plot, busy, done
  );

  modport slave (
    input  draw_req, erase_req, cur_x, cur_y, cursor_colour, ram_q,
    output ram_address, plot_x, plot_y, plot_colour, plot, busy, done
  );
endinterface

// File: rtl/cursor_draw_saveunder.sv
// Draws a SIZE x SIZE cursor into the framebuffer, saving the pixels it covers
// so that a later erase (or the first half of a move) can put them back.
`timescale 1ns/1ps
module cursor_draw_saveunder #(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  cursor_draw_saveunder_if.slave bus,
  output logic [2:0]             dbgState,
  output logic                   dbgSavedValid
);
  localparam int N  = SIZE * SIZE;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESTORE   = 3'd1,
    SAVE_ADDR = 3'd2,
    SAVE_PLOT = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       row, col;
  logic [7:0]          newX, savedX;
  logic [6:0]          newY, savedY;
  logic [COLOUR_W-1:0] newCol;
  logic                savedValid, drawPending;
  logic [COLOUR_W-1:0] saveBuf [1<<KW];
  logic [(1<<KW)-1:0]  bufValid;

  logic [14:0]         ramAddr;
  logic [7:0]          plotXReg;
  logic [6:0]          plotYReg;
  logic [COLOUR_W-1:0] plotColReg;
  logic                plotReg, busyReg, doneReg;

  function automatic logic [8:0] pxOf(input logic [7:0] bx, input logic [CW-1:0] c);
    return {1'b0, bx} + 9'(c);
  endfunction

  function automatic logic [7:0] pyOf(input logic [6:0] by, input logic [CW-1:0] r);
    return {1'b0, by} + 8'(r);
  endfunction

  function automatic logic inBounds(input logic [8:0] px, input logic [7:0] py);
    return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
  endfunction

  function automatic logic [14:0] addrOf(input logic [8:0] px, input logic [7:0] py);
    return 15'(px) + 15'(py) * 15'(SCREEN_W);
  endfunction

  function automatic logic [KW-1:0] idxOf(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return KW'(r) * KW'(SIZE) + KW'(c);
  endfunction

  // Scan position after the current one (row-major, wraps to 0 after the last).
  logic          lastCol, lastPix;
  logic [CW-1:0] nxtRow, nxtCol;
  assign lastCol = (col == CW'(SIZE - 1));
  assign lastPix = lastCol && (row == CW'(SIZE - 1));
  assign nxtCol  = lastCol ? '0 : col + 1'b1;
  assign nxtRow  = lastCol ? row + 1'b1 : row;

  // Outputs are registered, so the restore pixel and save address for the
  // pixel being entered are computed one edge ahead of their state.
  logic [CW-1:0]       rsRow, rsCol;
  logic [KW-1:0]       rsIdx;
  logic [8:0]          rsPx;
  logic [7:0]          rsPy;
  logic                rsValid;
  assign rsRow   = (state == IDLE) ? '0 : nxtRow;
  assign rsCol   = (state == IDLE) ? '0 : nxtCol;
  assign rsIdx   = idxOf(rsRow, rsCol);
  assign rsPx    = pxOf(savedX, rsCol);
  assign rsPy    = pyOf(savedY, rsRow);
  assign rsValid = bufValid[rsIdx];

  logic [CW-1:0] saRow, saCol;
  logic [7:0]    saBx;
  logic [6:0]    saBy;
  logic [14:0]   saAddr;
  assign saRow  = (state == SAVE_PLOT) ? nxtRow : '0;
  assign saCol  = (state == SAVE_PLOT) ? nxtCol : '0;
  assign saBx   = (state == IDLE) ? bus.cur_x : newX;
  assign saBy   = (state == IDLE) ? bus.cur_y : newY;
  assign saAddr = addrOf(pxOf(saBx, saCol), pyOf(saBy, saRow));

  logic [8:0]    curPx;
  logic [7:0]    curPy;
  logic          curIn;
  logic [KW-1:0] curIdx;
  assign curPx  = pxOf(newX, col);
  assign curPy  = pyOf(newY, row);
  assign curIn  = inBounds(curPx, curPy);
  assign curIdx = idxOf(row, col);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      newX        <= '0;
      newY        <= '0;
      newCol      <= '0;
      savedX      <= '0;
      savedY      <= '0;
      savedValid  <= 1'b0;
      drawPending <= 1'b0;
      bufValid    <= '0;
      ramAddr     <= '0;
      plotReg     <= 1'b0;
      plotXReg    <= '0;
      plotYReg    <= '0;
      plotColReg  <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      plotReg    <= 1'b0;
      plotXReg   <= '0;
      plotYReg   <= '0;
      plotColReg <= '0;
      doneReg    <= 1'b0;
      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
          if (bus.erase_req) begin
            drawPending <= 1'b0;
            busyReg     <= 1'b1;
            if (savedValid) begin
              state      <= RESTORE;
              plotReg    <= rsValid;
              plotXReg   <= rsValid ? 8'(rsPx) : '0;
              plotYReg   <= rsValid ? 7'(rsPy) : '0;
              plotColReg <= rsValid ? saveBuf[rsIdx] : '0;
            end else begin
              state   <= DONE;
              doneReg <= 1'b1;
            end
          end else if (bus.draw_req) begin
            newX    <= bus.cur_x;
            newY    <= bus.cur_y;
            newCol  <= bus.cursor_colour;
            busyReg <= 1'b1;
            if (savedValid) begin
              drawPending <= 1'b1;
              state       <= RESTORE;
              plotReg     <= rsValid;
              plotXReg    <= rsValid ? 8'(rsPx) : '0;
              plotYReg    <= rsValid ? 7'(rsPy) : '0;
              plotColReg  <= rsValid ? saveBuf[rsIdx] : '0;
            end else begin
              state   <= SAVE_ADDR;
              ramAddr <= saAddr;
            end
          end
        end
        RESTORE: begin
          if (lastPix) begin
            savedValid <= 1'b0;
            row        <= '0;
            col        <= '0;
            if (drawPending) begin
              drawPending <= 1'b0;
              state       <= SAVE_ADDR;
              ramAddr     <= saAddr;
            end else begin
              state   <= DONE;
              doneReg <= 1'b1;
            end
          end else begin
            row        <= nxtRow;
            col        <= nxtCol;
            plotReg    <= rsValid;
            plotXReg   <= rsValid ? 8'(rsPx) : '0;
            plotYReg   <= rsValid ? 7'(rsPy) : '0;
            plotColReg <= rsValid ? saveBuf[rsIdx] : '0;
          end
        end
        SAVE_ADDR: begin
          state      <= SAVE_PLOT;
          plotReg    <= curIn;
          plotXReg   <= curIn ? 8'(curPx) : '0;
          plotYReg   <= curIn ? 7'(curPy) : '0;
          plotColReg <= curIn ? newCol : '0;
        end
        SAVE_PLOT: begin
          saveBuf[curIdx]  <= bus.ram_q;
          bufValid[curIdx] <= curIn;
          if (lastPix) begin
            savedX     <= newX;
            savedY     <= newY;
            savedValid <= 1'b1;
            row        <= '0;
            col        <= '0;
            state      <= DONE;
            doneReg    <= 1'b1;
          end else begin
            row     <= nxtRow;
            col     <= nxtCol;
            state   <= SAVE_ADDR;
            ramAddr <= saAddr;
          end
        end
        DONE: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_address = ramAddr;
  assign bus.plot        = plotReg;
  assign bus.plot_x      = plotXReg;
  assign bus.plot_y      = plotYReg;
  assign bus.plot_colour = plotColReg;
  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign dbgState        = state;
  assign dbgSavedValid   = savedValid;
endmodule

// File: tb/tb_cursor_draw_saveunder.sv
// Directed bench for cursor_draw_saveunder: fresh draw, erase, clipped draw,
// move, simultaneous requests and mid-operation reset.
`timescale 1ns/1ps
module tb_cursor_draw_saveunder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cursor_draw_saveunder_if #(.COLOUR_W(3)) bus();
  logic [2:0] dbgState;
  logic       dbgSavedValid;

  cursor_draw_saveunder #(
    .SIZE(4), .SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .dbgState(dbgState),
    .dbgSavedValid(dbgSavedValid)
  );

  // Mirror RAM model: one-cycle read latency.
  logic [2:0] mem [0:19199];
  always @(posedge clk)
    bus.ram_q <= (bus.ram_address < 15'd19200) ? mem[bus.ram_address] : 3'd0;

  int checks = 0;
  int errors = 0;
  int leaks  = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [14:0] expAddr_q[$];
  logic [14:0] obsAddr_q[$];

  // Monitor: collect plot writes and save-phase read addresses.
  always @(negedge clk) begin
    if (bus.plot)
      obs_q.push_back({bus.plot_x, bus.plot_y, bus.plot_colour});
    else if ({bus.plot_x, bus.plot_y, bus.plot_colour} != 18'd0)
      leaks++;
    if (dbgState == 3'd2)
      obsAddr_q.push_back(bus.ram_address);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expDraw(input int bx, input int by, input logic [2:0] col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int px, py;
        px = bx + c;
        py = by + r;
        expAddr_q.push_back(15'(px + py * 160));
        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), col});
      end
  endtask

  task automatic expRestore(input int bx, input int by);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int px, py;
        px = bx + c;
        py = by + r;
        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), mem[px + py * 160]});
      end
  endtask

  task automatic runOp(input string tag, input logic d, input logic e,
                       input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] col, input int expLat);
    int lat;
    bit seen;
    @(negedge clk);
    obs_q.delete();
    obsAddr_q.delete();
    bus.draw_req = d;
    bus.erase_req = e;
    bus.cur_x = x;
    bus.cur_y = y;
    bus.cursor_colour = col;
    @(posedge clk);
    #1;
    bus.draw_req = 1'b0;
    bus.erase_req = 1'b0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      lat++;
      @(negedge clk);
      if (bus.done) seen = 1;
      else @(posedge clk);
    end
    check({tag, " latency"}, lat, expLat);
    @(negedge clk);
    check({tag, " plot count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, " plot"}, obs_q[i], exp_q[i]);
    check({tag, " addr count"}, obsAddr_q.size(), expAddr_q.size());
    for (int i = 0; i < obsAddr_q.size() && i < expAddr_q.size(); i++)
      check({tag, " addr"}, obsAddr_q[i], expAddr_q[i]);
    exp_q.delete();
    expAddr_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 3'((i * 7) + (i >> 5));
    bus.draw_req = 1'b0;
    bus.erase_req = 1'b0;
    bus.cur_x = '0;
    bus.cur_y = '0;
    bus.cursor_colour = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst plot", bus.plot, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst addr", bus.ram_address, 0);
    check("rst pixel", {bus.plot_x, bus.plot_y, bus.plot_colour}, 0);
    check("rst state", dbgState, 0);
    check("rst saved", dbgSavedValid, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Fresh draw then erase with pattern restore, then empty erase
    expDraw(10, 20, 3'b100);
    runOp("draw", 1, 0, 8'd10, 7'd20, 3'b100, 33);
    check("draw saved", dbgSavedValid, 1);
    check("draw idle busy", bus.busy, 0);
    expRestore(10, 20);
    runOp("erase", 0, 1, 8'd0, 7'd0, 3'b000, 17);
    check("erase saved", dbgSavedValid, 0);
    runOp("erase empty", 0, 1, 8'd0, 7'd0, 3'b000, 1);

    // Clipped corner draw and erase
    expDraw(158, 118, 3'b011);
    runOp("clip draw", 1, 0, 8'd158, 7'd118, 3'b011, 33);
    expRestore(158, 118);
    runOp("clip erase", 0, 1, 8'd0, 7'd0, 3'b000, 17);

    // Move: restore old region, then draw the new one
    expDraw(10, 20, 3'b110);
    runOp("move first", 1, 0, 8'd10, 7'd20, 3'b110, 33);
    expRestore(10, 20);
    expDraw(50, 60, 3'b001);
    runOp("move", 1, 0, 8'd50, 7'd60, 3'b001, 49);
    check("move saved", dbgSavedValid, 1);
    expRestore(50, 60);
    runOp("move erase", 0, 1, 8'd0, 7'd0, 3'b000, 17);

    // Both requests with nothing saved: erase wins
    runOp("both", 1, 1, 8'd30, 7'd30, 3'b111, 1);
    check("both saved", dbgSavedValid, 0);

    // Reset during SAVE_PLOT of pixel 5
    @(negedge clk);
    obs_q.delete();
    bus.draw_req = 1'b1;
    bus.cur_x = 8'd10;
    bus.cur_y = 7'd20;
    bus.cursor_colour = 3'b101;
    @(posedge clk);
    #1;
    bus.draw_req = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("abort state", dbgState, 3);
    check("abort pre done", bus.done, 0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort plots", obs_q.size(), 6);
    check("abort plot", bus.plot, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort addr", bus.ram_address, 0);
    check("abort pixel", {bus.plot_x, bus.plot_y, bus.plot_colour}, 0);
    check("abort saved", dbgSavedValid, 0);
    @(negedge clk);
    resetn = 1'b1;
    runOp("post abort erase", 0, 1, 8'd0, 7'd0, 3'b000, 1);

    check("zero when idle", leaks, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
